// File: rtl/gray_count_monitor.sv
// gray_count_monitor
//   Registers the Gray code produced by the free-running gray_counter,
//   decodes it to binary over a two-stage pipeline and checks that every new
//   value is a hold or a +1 step (mod 2^DATA_WIDTH). Illegal steps raise a
//   one-cycle step_err pulse, set err_sticky and bump a saturating err_count.
//
//   Optional feature macro: GRAY_MON_SYNC_EN
//     Adds a two-flop synchronizer ahead of stage 0 for a gray_in that comes
//     from another clock domain. Latency grows to 4 cycles and the FSM gains
//     two fill states.
//
//   Ports
//     clk         rising-edge clock, shared with gray_counter
//     reset       synchronous, active-high reset
//     gray_in     Gray code sampled every cycle
//     clr_err     synchronous clear of err_sticky / err_count
//     bin_out     decoded binary value (registered)
//     bin_valid   bin_out holds a decoded sample
//     step_err    one-cycle pulse, aligned with the offending bin_out
//     err_sticky  set on any step error, held until clr_err or reset
//     err_count   saturating count of step errors
//
//   State   | meaning
//   --------+-----------------------------------------------------------
//   EMPTY   | just out of reset, nothing valid in the pipeline
//   FILL1   | (sync build) first synchronizer flop holds a post-reset sample
//   FILL2   | (sync build) second synchronizer flop holds a post-reset sample
//   PRIMED  | g_q holds a valid sample; next edge loads the first bin_out
//   TRACK   | bin_out valid, every new value is step-checked

module gray_count_monitor #(
    parameter int DATA_WIDTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    gray_in,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    bin_out,
    output logic                     bin_valid,
    output logic                     step_err,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

`ifdef GRAY_MON_SYNC_EN
    typedef enum logic [2:0] {EMPTY, FILL1, FILL2, PRIMED, TRACK} state_t;
`else
    typedef enum logic [1:0] {EMPTY, PRIMED, TRACK} state_t;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] g_q;
    logic [DATA_WIDTH-1:0] g_src;
    logic [DATA_WIDTH-1:0] b_next;
    logic [DATA_WIDTH-1:0] delta;
    logic                  bad_step;

`ifdef GRAY_MON_SYNC_EN
    logic [DATA_WIDTH-1:0] sync1;
    logic [DATA_WIDTH-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gray_in;
            sync2 <= sync1;
        end
    end

    assign g_src = sync2;
`else
    assign g_src = gray_in;
`endif

    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign b_next = gray2bin(g_q);
    // Modular subtraction: wrap from all-ones to zero yields delta = 1.
    assign delta    = b_next - bin_out;
    assign bad_step = (state == TRACK) && (delta > DATA_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            g_q        <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            g_q      <= g_src;
            step_err <= 1'b0;

            case (state)
`ifdef GRAY_MON_SYNC_EN
                EMPTY:  state <= FILL1;
                FILL1:  state <= FILL2;
                FILL2:  state <= PRIMED;
`else
                EMPTY:  state <= PRIMED;
`endif
                PRIMED: begin
                    // First sample after reset is loaded without a step check.
                    bin_out   <= b_next;
                    bin_valid <= 1'b1;
                    state     <= TRACK;
                end
                TRACK: begin
                    bin_out  <= b_next;
                    step_err <= bad_step;
                end
                default: state <= EMPTY;
            endcase

            // An error arriving together with clr_err wins: the clear is
            // applied first, then the new error is counted.
            if (bad_step) begin
                err_sticky <= 1'b1;
                if (clr_err) begin
                    err_count <= ERR_CNT_WIDTH'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                end
            end else if (clr_err) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gray_count_monitor.sv
module tb_gray_count_monitor;

    localparam int W    = 4;
    localparam int CW   = 2;
    localparam int MOD  = 1 << W;
    localparam int CMAX = (1 << CW) - 1;
`ifdef GRAY_MON_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  gray_in;
    logic          clr_err;
    logic [W-1:0]  bin_out;
    logic          bin_valid;
    logic          step_err;
    logic          err_sticky;
    logic [CW-1:0] err_count;

    gray_count_monitor #(.DATA_WIDTH(W), .ERR_CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_in    (gray_in),
        .clr_err    (clr_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step_err   (step_err),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  bin;
        logic          valid;
        logic          err;
        logic          sticky;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- reference model ----------------
    int gray_hist[$];
    int m_n      = 0;
    int m_bin    = 0;
    bit m_valid  = 0;
    bit m_err    = 0;
    bit m_sticky = 0;
    int m_cnt    = 0;

    function automatic int g2b(input int g);
        int acc = 0;
        for (int s = 0; s < W; s++) acc = acc ^ (g >> s);
        return acc % MOD;
    endfunction

    function automatic logic [W-1:0] b2g(input int b);
        int v = b % MOD;
        return W'(v ^ (v >> 1));
    endfunction

    initial begin
        forever begin
            exp_t e;
            int   nb;
            int   d;
            @(posedge clk);
            gray_hist.push_back(int'(gray_in));
            if (gray_hist.size() > LAT) void'(gray_hist.pop_front());
            if (reset) begin
                m_n = 0; m_bin = 0; m_valid = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
            end else begin
                if (m_n < LAT) m_n++;
                m_err = 0;
                if (m_n >= LAT) begin
                    nb = g2b(gray_hist[0]);
                    d  = (nb - m_bin + MOD) % MOD;
                    if (m_valid && d > 1) m_err = 1;
                    m_bin   = nb;
                    m_valid = 1;
                end
                if (m_err) begin
                    m_sticky = 1;
                    m_cnt    = clr_err ? 1 : ((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1);
                end else if (clr_err) begin
                    m_sticky = 0;
                    m_cnt    = 0;
                end
            end
            e.bin    = W'(m_bin);
            e.valid  = m_valid;
            e.err    = m_err;
            e.sticky = m_sticky;
            e.cnt    = CW'(m_cnt);
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            exp_t e;
            exp_t a;
            @(posedge clk);
            #1;
            a = '{bin: bin_out, valid: bin_valid, err: step_err, sticky: err_sticky, cnt: err_count};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL no_expected t=%0t actual bin=%0d valid=%0b err=%0b sticky=%0b cnt=%0d",
                         $time, a.bin, a.valid, a.err, a.sticky, a.cnt);
            end else begin
                e = exp_q.pop_front();
                if (a === e) n_pass++;
                else
                    $display("FAIL outputs t=%0t actual bin=%0d valid=%0b err=%0b sticky=%0b cnt=%0d required bin=%0d valid=%0b err=%0b sticky=%0b cnt=%0d",
                             $time, a.bin, a.valid, a.err, a.sticky, a.cnt,
                             e.bin, e.valid, e.err, e.sticky, e.cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [W-1:0] g, input bit clr, input bit rst);
        @(negedge clk);
        gray_in = g;
        clr_err = clr;
        reset   = rst;
    endtask

    initial begin
        int b;
        reset   = 1'b1;
        gray_in = '0;
        clr_err = 1'b0;

        drive('0, 0, 1);
        drive('0, 0, 1);

        // Full count 0..15 and wrap to 0.
        for (int i = 0; i <= 16; i++) drive(b2g(i), 0, 0);

        // Count up to 4, then hold gray 0110.
        for (int i = 1; i <= 4; i++) drive(b2g(i), 0, 0);
        for (int i = 0; i < 5; i++) drive(4'b0110, 0, 0);

        // 4 -> 3 (backward), 3 -> 5 (jump), 5 -> 4 (single-bit backward).
        drive(4'b0010, 0, 0);
        drive(4'b0111, 0, 0);
        drive(4'b0110, 0, 0);
        for (int i = 0; i < 5; i++) drive(4'b0110, (i == 4), 0);
        for (int i = 0; i < LAT; i++) drive(4'b0110, 0, 0);

        // Five illegal jumps saturate the 2-bit counter.
        for (int i = 0; i < 5; i++) drive(b2g((i % 2 == 0) ? 8 : 0), 0, 0);
        // New error coincident with clr_err on the edge it reaches bin_out.
        drive(b2g(0), 0, 0);
        for (int j = 1; j < LAT; j++) drive(b2g(0), (j == LAT-1), 0);
        for (int i = 0; i < 3; i++) drive(b2g(0), 0, 0);

        // Reset mid-stream, then resume at gray 1100 (binary 8).
        drive(b2g(1), 0, 0);
        drive(b2g(2), 0, 0);
        drive(b2g(3), 0, 1);
        for (int i = 8; i < 8 + LAT + 4; i++) drive(b2g(i), 0, 0);

        // Randomized traffic: mostly legal, occasional jumps, clears, resets.
        b = 8 + LAT + 4;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      b = b + 1;
            else if (r < 85) b = b;
            else             b = $urandom_range(0, MOD - 1);
            drive(b2g(b), ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 2));
        end

        drive(b2g(b), 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gray_count_monitor.md
# gray_count_monitor

Downstream consumer of the free-running `gray_counter` output. Registers the Gray code, converts it to binary over a two-stage pipeline, and checks that every new value is either a hold or a +1 step modulo 2^DATA_WIDTH. Illegal steps produce an error pulse, a sticky flag and a saturating error count. The block presents the decoded binary count to the rest of the design and serves as the in-system health check for the counter.

## Interface
- `DATA_WIDTH`, 4: Gray/binary word width; must be ≥ 2.
- `ERR_CNT_WIDTH`, 8: width of the saturating error counter; must be ≥ 1.

- `clk`  in  1  rising-edge clock, shared with `gray_counter`.
- `reset`  in  1  synchronous, active-high reset.
- `gray_in`  in  DATA_WIDTH  Gray code from `gray_counter.out`, sampled every cycle.
- `clr_err`  in  1  synchronous clear of `err_sticky` and `err_count`.
- `bin_out`  out  DATA_WIDTH  decoded binary value, registered.
- `bin_valid`  out  1  high when `bin_out` holds a decoded sample.
- `step_err`  out  1  one-cycle pulse, aligned with the offending `bin_out`.
- `err_sticky`  out  1  set on any step error; held until `clr_err` or `reset`.
- `err_count`  out  ERR_CNT_WIDTH  number of step errors, saturating at all-ones.

## Operation
- Stage 0: `g_q <= gray_in` every cycle.
- Stage 1: `b = gray2bin(g_q)`, where `b[MSB] = g[MSB]` and `b[i] = b[i+1] ^ g[i]`. Register `b` into `bin_out`.
- Step check, in TRACK only: `delta = b - bin_out`, computed mod 2^DATA_WIDTH with the result truncated to DATA_WIDTH.
  - `delta` of 0 or 1 is legal.
  - Any other value sets `step_err` for the cycle in which `b` appears on `bin_out`.
  - Wrap from all-ones to 0 is legal (delta = 1).
- FSM states EMPTY → PRIMED → TRACK.
  - EMPTY: entered on reset. Unconditionally moves to PRIMED on the next edge.
  - PRIMED: `g_q` is valid. Next edge loads the first `bin_out`, sets `bin_valid`, enters TRACK. This first sample is never checked.
  - TRACK: stays in TRACK. Only `reset` leaves it.
- Error counter:
  - A step error increments `err_count` unless it is all-ones, and sets `err_sticky`.
  - `clr_err` alone zeroes both.
  - `clr_err` in the same cycle as a step error gives `err_count = 1` and `err_sticky = 1`; the error wins.
- `step_err` is never asserted while `bin_valid` is 0.

## Timing
- Reset values: `bin_out = 0`, `bin_valid = 0`, `step_err = 0`, `err_sticky = 0`, `err_count = 0`. Internal `g_q = 0`, state EMPTY.
- Latency from `gray_in` to `bin_out` is 2 cycles: sampled at edge N, visible after edge N+1.
- After `reset` deasserts, the first edge is EMPTY→PRIMED and the second loads `bin_out`. `bin_valid` is high after the 2nd edge.
- `step_err` and the updated `err_count`/`err_sticky` all change on the same edge as the offending `bin_out`.
- Reset mid-stream: all outputs return to reset values on the next edge. The first post-reset sample is unchecked, whatever its value.
- Throughput is one sample per cycle; there is no back-pressure.

## Configuration
- `GRAY_MON_SYNC_EN` defined:
  - Adds a two-flop synchronizer ahead of stage 0 for `gray_in` sourced from another clock domain.
  - Latency becomes 4 cycles.
  - The FSM gains two extra fill states (EMPTY, FILL1, FILL2, PRIMED, TRACK), so `bin_valid` rises after the 4th edge.
  - Reset clears the synchronizer flops to 0.
- Not defined: no synchronizer, 2-cycle latency, three-state FSM as above.

## Test plan
- Gray sequence 0000, 0001, 0011, 0010, … through 1000 then 0000 (DATA_WIDTH=4) → `bin_out` 0..15 then 0; `step_err` never high; `err_count = 0`.
- Hold `gray_in = 0110` for 5 cycles → `bin_out = 4` steady; no error.
- Gray 0010 → 0111 (binary 3 → 5) → one `step_err` pulse with `bin_out = 5`; `err_count = 1`; `err_sticky = 1`.
- Gray 0111 → 0110 (binary 5 → 4, single-bit change but backward) → `step_err` pulse; `err_count` increments.
- ERR_CNT_WIDTH=2, five illegal steps → `err_count = 3` (saturated). Then `clr_err` coincident with a new error → `err_count = 1`, `err_sticky = 1`.
- Assert `reset` for 1 cycle mid-stream, then resume at gray 1100 (binary 8) → all outputs 0 during reset; `bin_valid` high 2 edges later; `bin_out = 8`; no `step_err`.
